// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a sticky halt flag.
// Bus requests are answered one cycle later; queued bytes are serialised LSB first.
module mmio_uart_tx #(
  parameter logic [3:0] ADDR_HI  = 4'hf,
  parameter int         BAUD_DIV = 868,
  parameter int         FIFO_LOG = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  output logic        uart_tx,
  output logic        halt
);

  localparam int DEPTH = 1 << FIFO_LOG;
  localparam int BW    = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]     BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]     BAUD_ONE  = BW'(1);
  localparam logic [FIFO_LOG:0] CNT_FULL  = (FIFO_LOG + 1)'(DEPTH);
  localparam logic [FIFO_LOG:0] CNT_ONE   = (FIFO_LOG + 1)'(1);
  localparam logic [FIFO_LOG-1:0] PTR_ONE = FIFO_LOG'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              r_state;
  logic [BW-1:0]       r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic [7:0]          r_mem [DEPTH];
  logic [FIFO_LOG-1:0] r_wr_ptr;
  logic [FIFO_LOG-1:0] r_rd_ptr;
  logic [FIFO_LOG:0]   r_count;
  logic                r_ovf;
  logic                r_halt;
  logic                r_ready;
  logic [31:0]         r_rdata;

  state_t              w_state_next;
  logic [BW-1:0]       w_baud_next;
  logic [2:0]          w_bit_next;
  logic [7:0]          w_shift_next;
  logic                w_tx_next;
  logic                w_pop;

  logic       w_sel, w_rd, w_wr;
  logic [1:0] w_off;
  logic       w_full, w_empty, w_idle;
  logic       w_push_req, w_push;
  logic       w_baud_end;
  logic       w_unused;

  assign w_sel      = mem_oe && (mem_addr[31:28] == ADDR_HI);
  assign w_off      = mem_addr[3:2];
  assign w_rd       = w_sel && (mem_we == 4'b0000);
  assign w_wr       = w_sel && (mem_we != 4'b0000);
  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  assign w_idle     = w_empty && (r_state == S_IDLE);
  assign w_push_req = w_wr && (w_off == 2'd1) && mem_we[0];
  // Fullness uses the pre-cycle count, so a same-cycle pop never makes room.
  assign w_push     = w_push_req && !w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_unused   = ^{mem_addr[27:4], mem_addr[1:0], mem_wdata[31:8]};

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_baud_next  = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next   = r_bit + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (!w_empty) begin
            // Back-to-back frames: reload straight into the next start bit.
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_halt   <= 1'b0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_rd && (w_off == 2'd1)) begin
        r_ovf <= 1'b0;
      end else if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end
      if (w_wr && (w_off == 2'd0)) r_halt <= 1'b1;
      r_ready <= w_rd;
      r_rdata <= (w_rd && (w_off == 2'd1)) ? {29'b0, r_ovf, w_idle, !w_full} : 32'b0;
    end
  end

  assign uart_tx    = r_tx;
  assign halt       = r_halt;
  assign mmio_ready = r_ready;
  assign mmio_rdata = r_rdata;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed steps plus random bus traffic, checked every
// cycle against a frame-level reference model and a simple line receiver.
module tb_mmio_uart_tx;

  localparam int B  = 4;
  localparam int FL = 2;
  localparam int D  = 1 << FL;
  localparam logic [31:0] A_HALT = 32'hF000_0000;
  localparam logic [31:0] A_DATA = 32'hF000_0004;
  localparam logic [31:0] A_RES8 = 32'hF000_0008;
  localparam logic [31:0] A_RESC = 32'hF000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr = '0;
  logic        mem_oe = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_we = '0;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;
  logic        uart_tx;
  logic        halt;

  always #5 clk = ~clk;

  mmio_uart_tx #(.ADDR_HI(4'hf), .BAUD_DIV(B), .FIFO_LOG(FL)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mmio_rdata(mmio_rdata),
    .mmio_ready(mmio_ready), .uart_tx(uart_tx), .halt(halt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO as a queue, serializer as a position within a 10*B-cycle frame.
  logic [7:0]  m_q[$];
  int          m_pos = -1;
  logic [7:0]  m_cur = '0;
  logic        m_ovf = 1'b0;
  logic        m_halt = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        chk_en = 1'b0;

  task automatic model_step();
    logic sel, rd, wr, push_req, pre_full, pre_empty, pre_idle;
    logic [1:0] off;
    if (!rst) begin
      m_q.delete();
      m_pos = -1; m_ovf = 1'b0; m_halt = 1'b0; m_ready = 1'b0; m_rdata = '0;
    end else begin
      sel       = mem_oe && (mem_addr[31:28] == 4'hf);
      off       = mem_addr[3:2];
      rd        = sel && (mem_we == 4'b0);
      wr        = sel && (mem_we != 4'b0);
      push_req  = wr && (off == 2'd1) && mem_we[0];
      pre_full  = (m_q.size() == D);
      pre_empty = (m_q.size() == 0);
      pre_idle  = pre_empty && (m_pos < 0);
      m_ready   = rd;
      m_rdata   = (rd && off == 2'd1) ? {29'b0, m_ovf, pre_idle, !pre_full} : 32'b0;
      if (rd && off == 2'd1) m_ovf = 1'b0;
      else if (push_req && pre_full) m_ovf = 1'b1;
      if (wr && off == 2'd0) m_halt = 1'b1;
      if (m_pos >= 0) m_pos++;
      if ((m_pos < 0 || m_pos == 10 * B) && !pre_empty) begin
        m_cur = m_q.pop_front();
        m_pos = 0;
      end else if (m_pos == 10 * B) begin
        m_pos = -1;
      end
      if (push_req && !pre_full) m_q.push_back(mem_wdata[7:0]);
    end
  endtask

  function automatic logic exp_line();
    int idx;
    if (m_pos < 0) return 1'b1;
    idx = m_pos / B;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_cur[3'(idx - 1)];
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
  end

  // Line receiver: samples mid-bit, collects decoded bytes.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = '0;
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (uart_tx == 1'b0) begin rx_busy = 1'b1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if ((rx_cnt % B == B / 2) && (rx_cnt / B >= 1) && (rx_cnt / B <= 8))
        rx_byte[3'(rx_cnt / B - 1)] = uart_tx;
      if (rx_cnt == 10 * B - 1) begin rx_busy = 1'b0; rx_q.push_back(rx_byte); end
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk32("line", {31'b0, uart_tx}, {31'b0, exp_line()});
      chk32("halt", {31'b0, halt}, {31'b0, m_halt});
      chk32("ready", {31'b0, mmio_ready}, {31'b0, m_ready});
      chk32("rdata", mmio_rdata, m_rdata);
    end
  endtask

  task automatic drive(input logic oe, input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    tick();
    mem_oe = oe; mem_addr = a; mem_we = we; mem_wdata = d;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    $display("WR addr=%h we=%h data=%h", a, we, d);
    drive(1'b1, a, we, d);
    drive(1'b0, '0, '0, '0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic rdy);
    drive(1'b1, a, 4'b0, '0);
    drive(1'b0, '0, '0, '0);
    rd = mmio_rdata; rdy = mmio_ready;
    $display("RD addr=%h ready=%b data=%h", a, rdy, rd);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [3:0] hi;
    hi = ($urandom_range(0, 3) != 0) ? 4'hf : 4'($urandom);
    return {hi, 24'h0, 2'($urandom), 2'b00};
  endfunction

  initial begin
    logic [31:0] rd;
    logic        rdy;
    logic [9:0]  fr;
    logic [3:0]  we;
    int          w;

    // Reset with random bus activity
    rst = 1'b0;
    repeat (3) drive(1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom);
    drive(1'b0, '0, '0, '0);
    chk32("rst_tx", {31'b0, uart_tx}, 32'h1);
    chk32("rst_halt", {31'b0, halt}, 32'h0);
    chk32("rst_ready", {31'b0, mmio_ready}, 32'h0);
    chk32("rst_rdata", mmio_rdata, 32'h0);
    rst = 1'b1;
    bus_read(A_DATA, rd, rdy);
    chk32("init_ready", {31'b0, rdy}, 32'h1);
    chk32("init_status", rd, 32'h3);

    // Single byte 0x41
    rx_q.delete();
    bus_write(A_DATA, 4'hf, 32'h41);
    chk32("pre_start", {31'b0, uart_tx}, 32'h1);
    fr = 10'b1010000010;
    for (int i = 0; i < 10 * B; i++) begin
      tick();
      chk32("frame41", {31'b0, uart_tx}, {31'b0, fr[4'(i / B)]});
      if (i == 11) begin
        chk32("busy_ready", {31'b0, mmio_ready}, 32'h1);
        chk32("busy_status", mmio_rdata, 32'h1);
      end
      mem_oe = (i == 10); mem_addr = A_DATA; mem_we = 4'b0;
    end
    repeat (3) drive(1'b0, '0, '0, '0);
    bus_read(A_DATA, rd, rdy);
    chk32("done_status", rd, 32'h3);
    chk32("rx41_n", 32'(rx_q.size()), 32'd1);
    chk32("rx41", {24'b0, rx_q[0]}, 32'h41);

    // Overfill: 7 back-to-back writes, 5 survive
    rx_q.delete();
    for (int k = 0; k < 7; k++) begin
      $display("WR addr=%h we=f data=%h", A_DATA, 16 + k);
      drive(1'b1, A_DATA, 4'hf, 32'(16 + k));
    end
    bus_read(A_DATA, rd, rdy);
    chk32("ovf_status", rd, 32'h4);
    bus_read(A_DATA, rd, rdy);
    chk32("ovf_cleared", rd, 32'h0);
    repeat (5 * 10 * B + 10) drive(1'b0, '0, '0, '0);
    chk32("rx_burst_n", 32'(rx_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) chk32("rx_burst", {24'b0, rx_q[k]}, 32'(16 + k));

    // Halt and reserved offsets
    chk32("halt_pre", {31'b0, halt}, 32'h0);
    bus_write(A_HALT, 4'hf, 32'h0);
    chk32("halt_set", {31'b0, halt}, 32'h1);
    bus_write(A_RES8, 4'hf, 32'h55);
    repeat (4) drive(1'b0, '0, '0, '0);
    chk32("res8_tx", {31'b0, uart_tx}, 32'h1);
    bus_read(A_DATA, rd, rdy);
    chk32("res8_status", rd, 32'h3);
    bus_read(A_RESC, rd, rdy);
    chk32("resC_ready", {31'b0, rdy}, 32'h1);
    chk32("resC_rdata", rd, 32'h0);
    bus_read(A_HALT, rd, rdy);
    chk32("halt_rdata", rd, 32'h0);
    chk32("halt_hold", {31'b0, halt}, 32'h1);

    // Non-decoded accesses
    bus_write(A_DATA, 4'b0010, 32'h77);
    bus_write(32'h0000_1004, 4'hf, 32'h78);
    repeat (3) drive(1'b0, '0, '0, '0);
    bus_read(A_DATA, rd, rdy);
    chk32("nodec_status", rd, 32'h3);
    bus_read(32'h0000_1000, rd, rdy);
    chk32("outside_ready", {31'b0, rdy}, 32'h0);

    // Mid-frame reset during data bit 3
    rx_q.delete();
    bus_write(A_DATA, 4'hf, 32'hA5);
    repeat (18) tick();
    rst = 1'b0;
    tick();
    chk32("mid_rst_tx", {31'b0, uart_tx}, 32'h1);
    chk32("mid_rst_halt", {31'b0, halt}, 32'h0);
    tick();
    rst = 1'b1;
    bus_read(A_DATA, rd, rdy);
    chk32("mid_rst_status", rd, 32'h3);
    bus_write(A_DATA, 4'hf, 32'h3C);
    repeat (10 * B + 5) drive(1'b0, '0, '0, '0);
    chk32("rx_after_rst_n", 32'(rx_q.size()), 32'd1);
    chk32("rx_after_rst", {24'b0, rx_q[0]}, 32'h3C);

    // Random traffic against the model
    repeat (600) begin
      case ($urandom_range(0, 4))
        0, 1:    we = 4'h0;
        2:       we = 4'hf;
        3:       we = 4'h1;
        default: we = 4'h2;
      endcase
      if ($urandom_range(0, 9) < 6) begin
        drive(1'b1, rand_addr(), we, $urandom);
        $display("RND addr=%h we=%h data=%h", mem_addr, mem_we, mem_wdata);
      end else begin
        drive(1'b0, '0, '0, '0);
      end
    end
    w = 0;
    while (!(m_pos < 0 && m_q.size() == 0) && w < 20 * 10 * B) begin
      drive(1'b0, '0, '0, '0);
      w++;
    end
    bus_read(A_DATA, rd, rdy);
    bus_read(A_DATA, rd, rdy);
    chk32("drain_status", rd, 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that answers the processor's data-memory bus in the 0xF region (mem_addr[31:28]==ADDR_HI). It is the responder on the same mem_oe/mem_we/mem_ready bus the core drives, and it replaces the behavioural MMIO model with synthesizable hardware. It holds a halt flag, a byte FIFO and a status register, and it serialises queued bytes onto uart_tx as 8N1 frames.

Parameters:
ADDR_HI, 4'hf, value of mem_addr[31:28] that selects this block.
BAUD_DIV, 868, clk cycles per UART bit (100 MHz / 115200); legal range ≥2.
FIFO_LOG, 4, log2 of FIFO depth (16 entries).

Ports:
clk  input  1  clock, all state updates on posedge.
rst  input  1  synchronous reset, active-low.
mem_addr  input  32  byte address from the core; bits [1:0] are always 0.
mem_oe  input  1  request strobe, one cycle per request.
mem_wdata  input  32  write data.
mem_we  input  4  byte write enables; 0 means a read.
mmio_rdata  output  32  read data, valid while mmio_ready=1.
mmio_ready  output  1  read response strobe.
uart_tx  output  1  serial line, idle high.
halt  output  1  sticky halt request.

Behaviour:
- sel = mem_oe && mem_addr[31:28]==ADDR_HI. Only mem_addr[3:2] is decoded: offset 0x0 = HALT, 0x4 = DATA/STATUS, all other offsets are reserved.
- Reset (rst=0 at posedge): FIFO emptied, serializer set to IDLE, baud counter 0, overflow=0, halt=0, mmio_ready=0, mmio_rdata=0, uart_tx=1. A reset in mid-frame aborts the frame; uart_tx is 1 on the first cycle after reset.
- Write (sel && mem_we!=0):
  - HALT: sets halt=1 on the next cycle. halt holds until reset.
  - DATA with mem_we[0]=1: pushes mem_wdata[7:0]. If the FIFO is full, the byte is dropped and overflow is set. "Full" is judged on the pre-cycle count, so a same-cycle pop does not make room.
  - DATA with mem_we[0]=0: ignored.
  - Reserved offsets: ignored.
  - Writes never assert mmio_ready.
- Read (sel && mem_we==0):
  - mmio_ready=1 for exactly one cycle, on the cycle after the request. mmio_rdata is registered in that same cycle.
  - Latency is fixed at 1 and the block has no backpressure, so every read is answered.
  - DATA offset returns {29'b0, overflow, idle, !full}. idle means FIFO empty and serializer IDLE. !full in bit0 is the TX-available flag that software polls.
  - Reading DATA clears overflow; the returned value shows the pre-clear state.
  - HALT and reserved offsets read 0.
  - When mmio_ready=0, mmio_rdata=0.
- Back-to-back reads on consecutive cycles give consecutive ready pulses.
- FIFO:
  - Circular buffer of 2^FIFO_LOG bytes. Read and write pointers are FIFO_LOG bits and wrap naturally.
  - Count is FIFO_LOG+1 bits; full when count==2^FIFO_LOG, empty when count==0.
  - Simultaneous accepted push and pop leaves count unchanged.
- Serializer FSM (IDLE, START, DATA, STOP):
  - Baud counter counts 0..BAUD_DIV-1. A bit ends when counter==BAUD_DIV-1.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop into a shift register, clear the counter and go to START on the next cycle.
  - START: uart_tx=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[0], LSB first. Each bit lasts BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV cycles. On its last cycle, if the FIFO is non-empty, pop and go directly to START (no gap); otherwise go to IDLE.
- Timing:
  - A frame is 10*BAUD_DIV cycles.
  - The first start bit appears 2 cycles after the accepted write: 1 cycle to push, 1 cycle to pop.
- uart_tx is driven from a flop, so the line is glitch-free.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random bus activity → uart_tx=1, halt=0, mmio_ready=0, mmio_rdata=0. Then read 0xF0000004 → 1 cycle later mmio_ready=1, mmio_rdata=32'h3.
- Single byte, BAUD_DIV=4: write 0x41 to 0xF0000004 with we=4'hf → start bit begins 2 cycles later. Line sequence in 4-cycle bits is 0,1,0,0,0,0,0,1,0,1, then idle. A status read during the frame returns 32'h1; after the frame it returns 32'h3.
- Full FIFO, BAUD_DIV=4, FIFO_LOG=2: write 0x10..0x16 on consecutive cycles → 5 bytes are sent (one popped into the serializer plus 4 in the FIFO). The status read returns bit2=1 and bit0=0. A second read returns bit2=0. Frames 0x10..0x14 are contiguous with no idle gap.
- Halt and reserved offsets: write to 0xF0000000 → halt=1 next cycle and stays 1. Writes to 0xF0000008 have no effect. A read of 0xF000000C gives ready with rdata=0.
- Non-decoded accesses: a write with we=4'b0010 to DATA → nothing is queued. A read of 0x00001000 (outside ADDR_HI) → mmio_ready stays 0.
- Mid-frame reset: assert rst=0 during DATA bit 3 → the next cycle has uart_tx=1 and FIFO empty. After release, a new byte transmits correctly.
